ahb_dphase_mux: RTL
===================

// Module: ahb_dphase_mux
// PURPOSE
//  Parametrised NSLV:1 AHB-Lite read-response mux with data-phase select pipeline and built-in default slave.
//  Registers the address-phase HSEL vector when HREADY is high, then AND-OR muxes slave HRDATA/HREADYOUT/HRESP.
//  Unmapped NONSEQ/SEQ transfers get a two-cycle ERROR response.
//  Sits between the address decoder and the master in the ahblite interconnect; replaces fixed 4/8-way muxes.
// PARAMETERS
//  NSLV   8   number of slaves (1..32)
//  DW     32  HRDATA width in bits
// PORTS
//  HCLK         in   1         bus clock
//  HRESETn      in   1         asynchronous, active-low reset
//  hsel_i       in   NSLV      address-phase slave selects from decoder (expected one-hot or zero)
//  htrans_i     in   2         master HTRANS (address phase)
//  hrdata_i     in   NSLV*DW   slave read data, slave k at [k*DW +: DW]
//  hreadyout_i  in   NSLV      slave HREADYOUT
//  hresp_i      in   NSLV      slave HRESP (1 = ERROR)
//  hrdata_o     out  DW        muxed HRDATA to master
//  hready_o     out  1         muxed HREADY to master and all slaves
//  hresp_o      out  1         muxed HRESP to master
//  dsel_o       out  NSLV      registered data-phase select (one-hot or zero)
//  sel_err_o    out  1         one-cycle pulse: multi-hot hsel_i was captured
// BEHAVIOUR
//  Reset (async, HRESETn=0): dsel=0, def FSM=D_IDLE, sel_err_o=0 -> hready_o=1, hresp_o=0, hrdata_o=0.
//  Capture: on HCLK rise with hready_o=1: dsel <= first-set(hsel_i), lowest index wins.
//   - sel_err_o <= (popcount(hsel_i)>1). Cleared next capture.
//   - With hready_o=0: dsel and sel_err_o hold; hsel_i/htrans_i ignored.
//  Default slave FSM (one-hot encodes fine; states D_IDLE, D_ERR1, D_ERR2), transitions only when hready_o=1 or in D_ERR1:
//   - D_IDLE -> D_ERR1 : capture with hsel_i==0 and htrans_i[1]=1 (NONSEQ/SEQ).
//   - D_ERR1 -> D_ERR2 : unconditional, next cycle.
//   - D_ERR2 -> D_ERR1 : new unmapped NONSEQ/SEQ captured this cycle.
//   - D_ERR2 -> D_IDLE : otherwise.
//   - IDLE/BUSY with hsel_i==0 stays D_IDLE (zero-wait OKAY).
//  Outputs (combinational from registered state, zero added latency):
//   - dsel!=0: hrdata_o=OR_k(dsel[k]?hrdata_k:0); hready_o=OR_k(dsel[k]&hreadyout_k); hresp_o likewise.
//   - dsel==0, D_IDLE: hready_o=1, hresp_o=0.
//   - dsel==0, D_ERR1: hready_o=0, hresp_o=1.
//   - dsel==0, D_ERR2: hready_o=1, hresp_o=1.
//   - hrdata_o=0 whenever dsel==0.
//  Simultaneous events: D_ERR2 and slave/unmapped capture occur in the same cycle (pipelined, no bubble).
//  Selected slave inserting waits: hready_o follows its HREADYOUT; dsel held until it returns 1.
//  Reset mid-transfer: outputs return to reset values immediately; no pending error survives.
//  NSLV=1: first-set logic degenerates to wire; sel_err_o tied 0.
// STRUCTURE
//  ahb_defines.vh (shared): HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, D_IDLE/D_ERR1/D_ERR2 codes.
//  Sub-module pri_onehot #(.N(NSLV)): lowest-index first-set vector plus multi-hot flag; combinational, reusable by arbiter.
//  Top: dsel/sel_err registers, default FSM, generate-loop AND-OR mux.
// TESTING
//  1 Reset: HRESETn=0 mid-burst -> hready_o=1, hresp_o=0, hrdata_o=0, dsel_o=0 within same cycle.
//  2 Hit: NSLV=8, hsel_i=8'h04, NONSEQ, slave2 hrdata=32'hDEAD_BEEF, readyout=1 -> next cycle hrdata_o=DEADBEEF, hready_o=1, dsel_o=8'h04.
//  3 Wait: slave2 hreadyout=0 for 3 cycles -> hready_o=0 x3, dsel_o holds 8'h04 despite hsel_i=8'h10 during wait.
//  4 Unmapped: hsel_i=0, NONSEQ -> cycle+1 hready_o=0,hresp_o=1; cycle+2 hready_o=1,hresp_o=1; cycle+3 OKAY.
//  5 Back-to-back unmapped: second NONSEQ captured in D_ERR2 -> ERR1,ERR2,ERR1,ERR2 with no OKAY gap.
//  6 Multi-hot: hsel_i=8'h0A -> dsel_o=8'h02, sel_err_o=1 for one cycle; IDLE with hsel_i=0 -> zero-wait OKAY.

Source files
------------

// File: rtl/ahb_dphase_mux_pkg.sv
// Shared types and codes for the AHB-Lite data-phase response mux.
package ahb_dphase_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dstate_t;

endpackage

// File: rtl/ahb_dphase_mux_pri_onehot.sv
// Lowest-index-wins first-set vector plus a multi-hot flag; purely combinational.
module ahb_dphase_mux_pri_onehot #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] first_c,
  output logic         multi_c
);

  generate
    if (N == 1) begin : g_wire
      assign first_c = req;
      assign multi_c = 1'b0;
    end else begin : g_pri
      logic seen;
      always_comb begin
        first_c = '0;
        multi_c = 1'b0;
        seen    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
          if (req[i]) begin
            if (seen) multi_c = 1'b1;
            else first_c[i] = 1'b1;
            seen = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ahb_dphase_mux.sv
// NSLV:1 AHB-Lite read-response mux: registered data-phase select, AND-OR mux,
// and a built-in default slave answering unmapped transfers with a two-cycle ERROR.
module ahb_dphase_mux
  import ahb_dphase_mux_pkg::*;
#(
  parameter int unsigned NSLV = 8,
  parameter int unsigned DW   = 32
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NSLV-1:0]    hsel_i,
  input  logic [1:0]         htrans_i,
  input  logic [NSLV*DW-1:0] hrdata_i,
  input  logic [NSLV-1:0]    hreadyout_i,
  input  logic [NSLV-1:0]    hresp_i,
  output logic [DW-1:0]      hrdata_o,
  output logic               hready_o,
  output logic               hresp_o,
  output logic [NSLV-1:0]    dsel_o,
  output logic               sel_err_o
);

  logic [NSLV-1:0] first_sel;
  logic            multi_sel;
  logic [NSLV-1:0] dsel_q;
  logic            sel_err_q;
  dstate_t         state_q, state_d;
  logic            active_trans;
  logic            cap_unmapped;
  logic [DW-1:0]   mux_data;
  logic            mux_ready;
  logic            mux_resp;

  ahb_dphase_mux_pri_onehot #(.N(NSLV)) u_pri (
    .req     (hsel_i),
    .first_c (first_sel),
    .multi_c (multi_sel)
  );

  assign active_trans = (htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ);
  assign cap_unmapped = hready_o && (hsel_i == '0) && active_trans;

  // Address-phase capture only while the bus is ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q    <= '0;
      sel_err_q <= 1'b0;
    end else if (hready_o) begin
      dsel_q    <= first_sel;
      sel_err_q <= multi_sel;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= D_IDLE;
    else          state_q <= state_d;
  end

  // D_ERR2 can immediately re-enter D_ERR1 so back-to-back errors have no OKAY gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      D_IDLE:  if (cap_unmapped) state_d = D_ERR1;
      D_ERR1:  state_d = D_ERR2;
      D_ERR2:  state_d = cap_unmapped ? D_ERR1 : D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  // AND-OR mux of the data-phase slave responses.
  always_comb begin
    mux_data  = '0;
    mux_ready = 1'b0;
    mux_resp  = 1'b0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      mux_data  = mux_data | (hrdata_i[k*DW +: DW] & {DW{dsel_q[k]}});
      mux_ready = mux_ready | (dsel_q[k] & hreadyout_i[k]);
      mux_resp  = mux_resp | (dsel_q[k] & hresp_i[k]);
    end
  end

  always_comb begin
    hrdata_o = '0;
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    if (dsel_q != '0) begin
      hrdata_o = mux_data;
      hready_o = mux_ready;
      hresp_o  = mux_resp;
    end else begin
      unique case (state_q)
        D_ERR1: begin
          hready_o = 1'b0;
          hresp_o  = HRESP_ERROR;
        end
        D_ERR2: hresp_o = HRESP_ERROR;
        default: ;
      endcase
    end
  end

  assign dsel_o    = dsel_q;
  assign sel_err_o = sel_err_q;

endmodule
